// File: rtl/vga_frame_monitor_if.sv
// VGA output bundle plus the monitor's per-frame report.
// The generator side drives through master; the monitor consumes through slave.
interface vga_frame_monitor_if;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_n;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    logic       box_valid;
    logic       box_found;
    logic [9:0] box_xmin;
    logic [9:0] box_xmax;
    logic [8:0] box_ymin;
    logic [8:0] box_ymax;
    logic       line_err;
    logic       frame_err;
    logic       locked;

    modport master (
        output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_R, VGA_G, VGA_B,
        input  box_valid, box_found, box_xmin, box_xmax, box_ymin, box_ymax,
               line_err, frame_err, locked
    );

    modport slave (
        input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_R, VGA_G, VGA_B,
        output box_valid, box_found, box_xmin, box_xmax, box_ymin, box_ymax,
               line_err, frame_err, locked
    );
endinterface

// File: rtl/vga_frame_monitor.sv
// Recovers pixel column/row from a VGA bundle and reports, once per frame,
// the bounding box of lit pixels plus line-length and frame-length errors.
module vga_frame_monitor #(
    parameter logic [7:0]  THRESH = 8'h80,
    parameter int unsigned HPIX   = 640,
    parameter int unsigned VLINES = 480
) (
    input  logic               clk,
    input  logic               reset,
    vga_frame_monitor_if.slave vga
);

    localparam logic [9:0] HPIX_C   = 10'(HPIX);
    localparam logic [8:0] VLINES_C = 9'(VLINES);
    localparam logic [9:0] COL_MAX  = 10'h3ff;
    localparam logic [8:0] ROW_MAX  = 9'h1ff;

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } state_e;

    state_e state_q, state_d;

    logic       vga_clk_s1_q, vga_clk_d1_q;
    logic       unused_hs_s1_q;
    logic       vs_s1_q, blank_s1_q;
    logic [7:0] r_s1_q, g_s1_q, b_s1_q;
    logic       vs_prev_q, blank_prev_q;

    logic [9:0] col_q, col_d;
    logic [8:0] row_q, row_d;
    logic       found_q, found_d;
    logic [9:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [8:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic       line_err_acc_q, line_err_acc_d;
    logic       frame_err_acc_q, frame_err_acc_d;

    logic       box_valid_q, box_found_q, line_err_q, frame_err_q;
    logic [9:0] box_xmin_q, box_xmax_q;
    logic [8:0] box_ymin_q, box_ymax_q;

    logic pix, blank_fall, vs_fall, lit, publish, clear;

    assign pix        = vga_clk_s1_q & ~vga_clk_d1_q;
    assign blank_fall = pix & blank_prev_q & ~blank_s1_q;
    assign vs_fall    = pix & vs_prev_q & ~vs_s1_q;
    assign lit        = pix & blank_s1_q & (r_s1_q >= THRESH) &
                        (g_s1_q >= THRESH) & (b_s1_q >= THRESH);

    // Line-level accumulation; frame closure later consumes these _d values,
    // so a blank_fall coincident with vs_fall is folded in before publishing.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        col_d           = col_q;
        row_d           = row_q;
        found_d         = found_q;
        xmin_d          = xmin_q;
        xmax_d          = xmax_q;
        ymin_d          = ymin_q;
        ymax_d          = ymax_q;
        line_err_acc_d  = line_err_acc_q;
        frame_err_acc_d = frame_err_acc_q;

        if (lit) begin
            found_d = 1'b1;
            if (!found_q) begin
                xmin_d = col_q;
                xmax_d = col_q;
                ymin_d = row_q;
                ymax_d = row_q;
            end else begin
                if (col_q < xmin_q) xmin_d = col_q;
                if (col_q > xmax_q) xmax_d = col_q;
                if (row_q < ymin_q) ymin_d = row_q;
                if (row_q > ymax_q) ymax_d = row_q;
            end
        end

        if (pix && blank_s1_q) begin
            if (col_q == COL_MAX) line_err_acc_d = 1'b1;
            else                  col_d          = col_q + 10'd1;
        end

        if (blank_fall) begin
            if (col_q != HPIX_C) line_err_acc_d = 1'b1;
            col_d = '0;
            if (row_q == ROW_MAX) frame_err_acc_d = 1'b1;
            else                  row_d           = row_q + 9'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            ST_UNLOCKED: begin
                if (vs_fall) begin
                    state_d = ST_LOCKED;
                    clear   = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (vs_fall) begin
                    publish = 1'b1;
                    clear   = 1'b1;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= ST_UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_clk_s1_q    <= 1'b0;
            vga_clk_d1_q    <= 1'b0;
            unused_hs_s1_q  <= 1'b0;
            vs_s1_q         <= 1'b0;
            blank_s1_q      <= 1'b0;
            r_s1_q          <= '0;
            g_s1_q          <= '0;
            b_s1_q          <= '0;
            vs_prev_q       <= 1'b0;
            blank_prev_q    <= 1'b0;
            col_q           <= '0;
            row_q           <= '0;
            found_q         <= 1'b0;
            xmin_q          <= '0;
            xmax_q          <= '0;
            ymin_q          <= '0;
            ymax_q          <= '0;
            line_err_acc_q  <= 1'b0;
            frame_err_acc_q <= 1'b0;
            box_valid_q     <= 1'b0;
            box_found_q     <= 1'b0;
            box_xmin_q      <= '0;
            box_xmax_q      <= '0;
            box_ymin_q      <= '0;
            box_ymax_q      <= '0;
            line_err_q      <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            vga_clk_s1_q   <= vga.VGA_CLK;
            vga_clk_d1_q   <= vga_clk_s1_q;
            unused_hs_s1_q <= vga.VGA_HS;
            vs_s1_q        <= vga.VGA_VS;
            blank_s1_q     <= vga.VGA_BLANK_n;
            r_s1_q         <= vga.VGA_R;
            g_s1_q         <= vga.VGA_G;
            b_s1_q         <= vga.VGA_B;

            if (pix) begin
                vs_prev_q    <= vs_s1_q;
                blank_prev_q <= blank_s1_q;
            end

            if (clear) begin
                col_q           <= '0;
                row_q           <= '0;
                found_q         <= 1'b0;
                xmin_q          <= '0;
                xmax_q          <= '0;
                ymin_q          <= '0;
                ymax_q          <= '0;
                line_err_acc_q  <= 1'b0;
                frame_err_acc_q <= 1'b0;
            end else begin
                col_q           <= col_d;
                row_q           <= row_d;
                found_q         <= found_d;
                xmin_q          <= xmin_d;
                xmax_q          <= xmax_d;
                ymin_q          <= ymin_d;
                ymax_q          <= ymax_d;
                line_err_acc_q  <= line_err_acc_d;
                frame_err_acc_q <= frame_err_acc_d;
            end

            box_valid_q <= publish;
            if (publish) begin
                box_found_q <= found_d;
                box_xmin_q  <= found_d ? xmin_d : '0;
                box_xmax_q  <= found_d ? xmax_d : '0;
                box_ymin_q  <= found_d ? ymin_d : '0;
                box_ymax_q  <= found_d ? ymax_d : '0;
                line_err_q  <= line_err_acc_d;
                frame_err_q <= frame_err_acc_d | (row_d != VLINES_C);
            end
        end
    end

    assign vga.box_valid = box_valid_q;
    assign vga.box_found = box_found_q;
    assign vga.box_xmin  = box_xmin_q;
    assign vga.box_xmax  = box_xmax_q;
    assign vga.box_ymin  = box_ymin_q;
    assign vga.box_ymax  = box_ymax_q;
    assign vga.line_err  = line_err_q;
    assign vga.frame_err = frame_err_q;
    assign vga.locked    = (state_q == ST_LOCKED);

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Receive-side companion to the VGA display generator: consumes the VGA output bundle (pixel clock, syncs, blank, RGB) on the 50 MHz system clock and recovers pixel column and row from the signals alone. Each frame it reports the bounding box of all "lit" pixels plus line-length and frame-length errors. Used in simulation and on-chip to confirm sprite placement and raster timing without access to the generator's internal counters.

## Interface

- THRESH, 8'h80: per-channel minimum; a pixel is lit when R, G and B are all >= THRESH.
- HPIX, 640: required active pixels per line.
- VLINES, 480: required active lines per frame.

- clk  in  1  50 MHz system clock, same clock as the generator.
- reset  in  1  synchronous, active-high.
- VGA_CLK  in  1  25 MHz pixel clock; pixel sampled on its rising edge.
- VGA_HS  in  1  horizontal sync, active low.
- VGA_VS  in  1  vertical sync, active low.
- VGA_BLANK_n  in  1  high during active video.
- VGA_R, VGA_G, VGA_B  in  8 each  pixel colour.
- box_valid  out  1  one-cycle pulse; report fields below are valid on and after this cycle.
- box_found  out  1  at least one lit pixel in reported frame.
- box_xmin, box_xmax  out  10  lit-pixel column bounds.
- box_ymin, box_ymax  out  9  lit-pixel row bounds.
- line_err  out  1  some active line in reported frame had length != HPIX.
- frame_err  out  1  reported frame had active-line count != VLINES.
- locked  out  1  monitor has seen a frame start since reset.

## Operation

- Input stage: all VGA inputs registered once (s1). Pixel strobe `pix` = s1 VGA_CLK high and previous-cycle s1 VGA_CLK low. All counters and compares act only on `pix` cycles using s1 values.
- Edge detects (evaluated on `pix`, against value at previous `pix`): blank_fall = BLANK_n 1->0; vs_fall = VS 1->0.
- Column counter col[9:0]: on `pix` with BLANK_n=1: compare/accumulate at col, then col+1, saturating at 1023 (sets line_err_acc). On blank_fall: if col != HPIX set line_err_acc; col <= 0; row <= row+1 (saturating at 511, sets frame_err_acc).
- Lit pixel at (col,row): update xmin=min, xmax=max, ymin=min, ymax=max, found_acc=1. First lit pixel of frame loads all four bounds directly.
- FSM, two states:
  - UNLOCKED (reset state): accumulators ignored. On vs_fall -> LOCKED, clear col, row, all accumulators; no report.
  - LOCKED: on vs_fall: publish report (box_* <= accumulators, line_err <= line_err_acc, frame_err <= frame_err_acc | (row != VLINES)), pulse box_valid, then clear col, row, accumulators. Stays LOCKED; errors never drop lock.
- box_found=0 report: box_xmin/xmax/ymin/ymax all published as 0.
- Simultaneous blank_fall and vs_fall on same `pix`: line closure applied first, then frame closure sees the incremented row.
- Report fields hold until next publish or reset.

## Timing

- Reset: every output 0, FSM UNLOCKED, all counters and accumulators 0, s1 stage cleared. Reset mid-frame discards the partial frame; first vs_fall afterwards only locks.
- Latency: VGA input change -> s1 at +1 clk; `pix` asserted the cycle s1 VGA_CLK first reads 1; report registers and box_valid update at the clk edge after that `pix` cycle (vs_fall at input pin -> box_valid high 2 clk later when coincident with a VGA_CLK rise).
- box_valid high exactly 1 clk per frame; at most one pulse per vs_fall.
- locked rises the clk after the locking vs_fall and stays high until reset.
- No back-pressure; report must be consumed before next vs_fall (~16.8 ms).

## Test plan

- Reset mid-frame, blank-blue raster from standard 640x480 generator: no box_valid at first vs_fall, locked=1; second vs_fall -> box_valid 1 clk, box_found=0, all bounds 0, line_err=0, frame_err=0.
- Single white (FF,FF,FF) pixel at column 100 row 50 -> box_xmin=box_xmax=100, box_ymin=box_ymax=50, box_found=1.
- Filled 64x32 white sprite, top-left (200,300) -> xmin=200, xmax=263, ymin=300, ymax=331, no errors.
- Pixel (7F,FF,FF) at (10,10) plus (80,80,80) at (20,20) -> only latter counted: bounds 20/20/20/20.
- Line 5 truncated to 639 active pixels -> that frame's report line_err=1, frame_err=0; next clean frame reports line_err=0.
- Only 479 active lines in a frame -> frame_err=1; reset asserted for 1 clk mid-next-frame -> all outputs 0 next cycle, locked=0, no box_valid until second following vs_fall.
